jt6295_rom_arb: RTL and testbench

Arbiter that shares one external sound-ROM port between two ADPCM cores (dual-OKI boards). Each core presents an 18-bit byte address through a cs/ok handshake. The arbiter applies per-core bank switching and a fixed region offset, then serialises the accesses onto a single 22-bit ROM bus with round-robin priority. It sits between the two core instances and the SDRAM/ROM download controller.

---
 rtl/jt6295_rom_arb_if.sv | 39 +++
 rtl/jt6295_rom_arb.sv | 146 ++++++++++++++
 tb/tb_jt6295_rom_arb.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/jt6295_rom_arb_if.sv
// ----------------------------------------------------------------------------
// jt6295_rom_arb_if
// Bundles the signals between the ROM arbiter, its two ADPCM cores, the bank
// register writer and the external ROM port.
//   cs0/addr0/dout0/ok0 : core 0 fetch handshake (18-bit byte address, 8-bit data)
//   cs1/addr1/dout1/ok1 : core 1 fetch handshake
//   bank_we/sel/din     : one-cycle bank register write (5-bit bank value)
//   rom_cs/rom_addr     : shared external request and 22-bit byte address
//   rom_data/rom_ok     : external read data and its valid strobe
// Modport master is the arbiter's view; slave is the view of everything
// around it (cores, bank writer, ROM).
// ----------------------------------------------------------------------------
interface jt6295_rom_arb_if;
    logic        cs0;
    logic [17:0] addr0;
    logic [7:0]  dout0;
    logic        ok0;
    logic        cs1;
    logic [17:0] addr1;
    logic [7:0]  dout1;
    logic        ok1;
    logic        bank_we;
    logic        bank_sel;
    logic [4:0]  bank_din;
    logic        rom_cs;
    logic [21:0] rom_addr;
    logic [7:0]  rom_data;
    logic        rom_ok;

    modport master (
        input  cs0, addr0, cs1, addr1, bank_we, bank_sel, bank_din, rom_data, rom_ok,
        output dout0, ok0, dout1, ok1, rom_cs, rom_addr
    );

    modport slave (
        output cs0, addr0, cs1, addr1, bank_we, bank_sel, bank_din, rom_data, rom_ok,
        input  dout0, ok0, dout1, ok1, rom_cs, rom_addr
    );
endinterface

// File: rtl/jt6295_rom_arb.sv
// ----------------------------------------------------------------------------
// jt6295_rom_arb
// Shares one external sound-ROM port between two ADPCM cores. Each core's
// 18-bit address is mapped through its bank register (upper half of the core
// space is banked), core 1 is moved up by OFFSET1, and requests are
// serialised onto the ROM bus with round-robin priority.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : jt6295_rom_arb_if.master (core handshakes, bank write, ROM bus)
// ----------------------------------------------------------------------------
module jt6295_rom_arb #(
    parameter logic [21:0] OFFSET1 = 22'h10_0000
) (
    input  logic              clk,
    input  logic              rst,
    jt6295_rom_arb_if.master  bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, BUSY = 2'd2} state_t;

    state_t      state_q, state_d;

    logic [4:0]  bank0_q, bank1_q;
    logic [17:0] saddr0_q, saddr1_q;     // raw address each core's data belongs to
    logic        valid0_q, valid1_q;
    logic        dirty0_q, dirty1_q;     // bank written while this core's fetch was in flight
    logic [7:0]  dout0_q, dout1_q;
    logic        gid_q;                  // core owning the current transfer
    logic [17:0] gaddr_q;                // raw address captured at grant
    logic [21:0] rom_addr_q;
    logic        last_q;                 // core granted most recently

    logic [21:0] eff0, eff1;
    logic        pend0, pend1;
    logic        grant, gnt_id, done;
    logic        bw0, bw1, fly0, fly1;

    function automatic logic [21:0] map_addr(input logic [17:0] a, input logic [4:0] bank);
        return a[17] ? {bank, a[16:0]} : {4'd0, a};
    endfunction

    assign eff0  = map_addr(bus.addr0, bank0_q);
    assign eff1  = map_addr(bus.addr1, bank1_q) + OFFSET1;   // wraps modulo 2^22

    assign pend0 = bus.cs0 & (~valid0_q | (bus.addr0 != saddr0_q));
    assign pend1 = bus.cs1 & (~valid1_q | (bus.addr1 != saddr1_q));

    // ok is a live compare so it drops in the same cycle the core moves on
    assign bus.ok0   = bus.cs0 & valid0_q & (bus.addr0 == saddr0_q);
    assign bus.ok1   = bus.cs1 & valid1_q & (bus.addr1 == saddr1_q);
    assign bus.dout0 = dout0_q;
    assign bus.dout1 = dout1_q;
    assign bus.rom_addr = rom_addr_q;

    assign grant  = (state_q == IDLE) & (pend0 | pend1);
    assign gnt_id = (pend0 & pend1) ? ~last_q : pend1;
    assign done   = (state_q == BUSY) & bus.rom_ok;

    assign bw0 = bus.bank_we & ~bus.bank_sel;
    assign bw1 = bus.bank_we &  bus.bank_sel;

    // A core is in flight from its grant edge until completion; a bank write
    // on the grant edge also makes the captured (old-bank) address stale.
    assign fly0 = (state_q != IDLE) ? ~gid_q : (grant & ~gnt_id);
    assign fly1 = (state_q != IDLE) ?  gid_q : (grant &  gnt_id);

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pend0 | pend1) state_d = WAIT;
            WAIT:    state_d = BUSY;         // rom_ok may still be left over from the last access
            BUSY:    if (bus.rom_ok) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        bus.rom_cs = 1'b0;
        if (state_q == WAIT || state_q == BUSY) bus.rom_cs = 1'b1;
    end

    // Grant capture and round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gid_q      <= 1'b0;
            gaddr_q    <= '0;
            rom_addr_q <= '0;
            last_q     <= 1'b1;
        end else if (grant) begin
            gid_q      <= gnt_id;
            gaddr_q    <= gnt_id ? bus.addr1 : bus.addr0;
            rom_addr_q <= gnt_id ? eff1 : eff0;
            last_q     <= gnt_id;
        end
    end

    // Per-core bank, validity and data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank0_q  <= '0;
            bank1_q  <= '0;
            valid0_q <= 1'b0;
            valid1_q <= 1'b0;
            dirty0_q <= 1'b0;
            dirty1_q <= 1'b0;
            saddr0_q <= '0;
            saddr1_q <= '0;
            dout0_q  <= '0;
            dout1_q  <= '0;
        end else begin
            if (done && !gid_q) begin
                dout0_q  <= bus.rom_data;
                saddr0_q <= gaddr_q;
                valid0_q <= ~dirty0_q;
                dirty0_q <= 1'b0;
            end else if (bw0 && fly0) begin
                dirty0_q <= 1'b1;
            end
            if (done && gid_q) begin
                dout1_q  <= bus.rom_data;
                saddr1_q <= gaddr_q;
                valid1_q <= ~dirty1_q;
                dirty1_q <= 1'b0;
            end else if (bw1 && fly1) begin
                dirty1_q <= 1'b1;
            end
            // a bank write always invalidates, even on the completion edge
            if (bw0) begin
                bank0_q  <= bus.bank_din;
                valid0_q <= 1'b0;
            end
            if (bw1) begin
                bank1_q  <= bus.bank_din;
                valid1_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_jt6295_rom_arb.sv
module tb_jt6295_rom_arb;
    localparam logic [21:0] OFFSET1 = 22'h10_0000;

    typedef struct {
        logic        core;
        logic [21:0] addr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t sb[$];
    logic [4:0] mb [2];
    logic mdl_last;

    jt6295_rom_arb_if rif();

    jt6295_rom_arb #(.OFFSET1(OFFSET1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (rif.master)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] romfn(input logic [21:0] a);
        return a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]} ^ 8'h78;
    endfunction

    assign rif.rom_data = romfn(rif.rom_addr);

    function automatic logic [21:0] m_eff(input logic core, input logic [17:0] a);
        logic [21:0] e;
        e = a[17] ? {mb[core], a[16:0]} : {4'd0, a};
        if (core) e = e + OFFSET1;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic core, input logic [17:0] a);
        exp_t e;
        e.core = core;
        e.addr = m_eff(core, a);
        sb.push_back(e);
        mdl_last = core;
    endtask

    task automatic push_tie(input logic [17:0] a0, input logic [17:0] a1);
        if (mdl_last) begin
            push(1'b0, a0);
            push(1'b1, a1);
        end else begin
            push(1'b1, a1);
            push(1'b0, a0);
        end
    endtask

    task automatic pop(output exp_t e);
        check("sb_nonempty", (sb.size() > 0), 1);
        if (sb.size() > 0) e = sb.pop_front();
        else begin
            e.core = 1'b0;
            e.addr = '0;
        end
    endtask

    // wait for the next transfer, compare its address, then its delivered data
    task automatic serve_next();
        exp_t e;
        int   n;
        n = 0;
        while (!rif.rom_cs && n < 50) begin tick(1); n++; end
        check("rom_cs_rise", rif.rom_cs, 1);
        pop(e);
        check("rom_addr", rif.rom_addr, e.addr);
        n = 0;
        while (rif.rom_cs && n < 50) begin tick(1); n++; end
        check("rom_cs_fall", rif.rom_cs, 0);
        check(e.core ? "ok1" : "ok0", e.core ? rif.ok1 : rif.ok0, 1);
        check(e.core ? "dout1" : "dout0", e.core ? rif.dout1 : rif.dout0, romfn(e.addr));
    endtask

    task automatic bank_write(input logic sel, input logic [4:0] val);
        rif.bank_we  = 1'b1;
        rif.bank_sel = sel;
        rif.bank_din = val;
        tick(1);
        rif.bank_we  = 1'b0;
        mb[sel] = val;
    endtask

    initial begin
        exp_t e;
        logic [17:0] a0, a1;

        rif.cs0 = 0; rif.addr0 = '0; rif.cs1 = 0; rif.addr1 = '0;
        rif.bank_we = 0; rif.bank_sel = 0; rif.bank_din = '0; rif.rom_ok = 1'b1;
        mb[0] = '0; mb[1] = '0; mdl_last = 1'b1;

        // reset state
        #3 rst = 1'b1;
        tick(2);
        check("rst_rom_cs", rif.rom_cs, 0);
        check("rst_rom_addr", rif.rom_addr, 0);
        check("rst_ok0", rif.ok0, 0);
        check("rst_ok1", rif.ok1, 0);
        check("rst_dout0", rif.dout0, 0);
        check("rst_dout1", rif.dout1, 0);
        rst = 1'b0;
        tick(1);

        // single request, exact latency
        rif.cs0 = 1'b1; rif.addr0 = 18'h00123;
        push(1'b0, rif.addr0);
        tick(1);
        check("single_cs_t0", rif.rom_cs, 1);
        pop(e);
        check("single_addr", rif.rom_addr, e.addr);
        check("single_addr_abs", rif.rom_addr, 22'h000123);
        check("single_ok_t0", rif.ok0, 0);
        tick(1);
        check("single_cs_t1", rif.rom_cs, 1);
        check("single_addr_t1", rif.rom_addr, 22'h000123);
        check("single_ok_t1", rif.ok0, 0);
        tick(1);
        check("single_cs_t2", rif.rom_cs, 0);
        check("single_ok_t2", rif.ok0, 1);
        check("single_dout", rif.dout0, 8'h5A);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("single_hold_cs", rif.rom_cs, 0);
            check("single_hold_ok", rif.ok0, 1);
        end
        rif.cs0 = 1'b0;
        tick(1);
        check("cs0_drop_ok", rif.ok0, 0);

        // banking and core-1 offset
        bank_write(1'b1, 5'h03);
        rif.cs1 = 1'b1; rif.addr1 = 18'h2_0004;
        push(1'b1, rif.addr1);
        check("bank1_model", m_eff(1'b1, 18'h2_0004), 22'h16_0004);
        serve_next();
        rif.cs1 = 1'b0;
        bank_write(1'b0, 5'h1F);
        rif.cs0 = 1'b1; rif.addr0 = 18'h3_FFFF;
        push(1'b0, rif.addr0);
        check("bank0_model", m_eff(1'b0, 18'h3_FFFF), 22'h3F_FFFF);
        serve_next();
        rif.cs0 = 1'b0;
        tick(1);

        // contention: 8 ties; odd ones follow a solo core-0 fetch
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 1) begin
                rif.cs0 = 1'b1; rif.addr0 = 18'h03000 + 18'(i);
                push(1'b0, rif.addr0);
                serve_next();
            end
            a0 = 18'h00200 + 18'(i * 16) + (i[0] ? 18'h20000 : 18'h0);
            a1 = 18'h01000 + 18'(i * 16) + (i[1] ? 18'h20000 : 18'h0);
            rif.cs0 = 1'b1; rif.addr0 = a0;
            rif.cs1 = 1'b1; rif.addr1 = a1;
            push_tie(a0, a1);
            serve_next();
            serve_next();
            check("tie_both_ok", {rif.ok0, rif.ok1}, 2'b11);
        end

        // slow ROM: stale rom_ok during WAIT, then 5 low cycles
        rif.addr0 = 18'h00777;
        push(1'b0, rif.addr0);
        tick(1);
        check("slow_cs_grant", rif.rom_cs, 1);
        pop(e);
        check("slow_addr", rif.rom_addr, e.addr);
        tick(1);
        check("slow_stale_ignored", rif.rom_cs, 1);
        rif.rom_ok = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("slow_cs_hold", rif.rom_cs, 1);
            check("slow_addr_hold", rif.rom_addr, e.addr);
            check("slow_ok0_low", rif.ok0, 0);
        end
        rif.rom_ok = 1'b1;
        tick(1);
        check("slow_cs_done", rif.rom_cs, 0);
        check("slow_ok0", rif.ok0, 1);
        check("slow_dout0", rif.dout0, romfn(e.addr));

        // bank write while core 0 is in BUSY
        rif.rom_ok = 1'b0;
        rif.addr0 = 18'h2_0010;
        push(1'b0, rif.addr0);
        tick(1);
        pop(e);
        check("bw_addr_old", rif.rom_addr, e.addr);
        tick(2);
        check("bw_busy_cs", rif.rom_cs, 1);
        bank_write(1'b0, 5'h02);
        rif.rom_ok = 1'b1;
        tick(1);
        check("bw_done_cs", rif.rom_cs, 0);
        check("bw_ok0_low", rif.ok0, 0);
        check("bw_dout_old", rif.dout0, romfn(e.addr));
        push(1'b0, rif.addr0);
        check("bw_model_new", m_eff(1'b0, 18'h2_0010), 22'h04_0010);
        serve_next();

        // async reset mid-transfer
        rif.rom_ok = 1'b0;
        rif.addr0 = 18'h00456;
        tick(1);
        check("ar_cs_before", rif.rom_cs, 1);
        #2 rst = 1'b1;
        #1;
        check("ar_rom_cs", rif.rom_cs, 0);
        check("ar_rom_addr", rif.rom_addr, 0);
        check("ar_ok0", rif.ok0, 0);
        check("ar_ok1", rif.ok1, 0);
        check("ar_dout0", rif.dout0, 0);
        check("ar_dout1", rif.dout1, 0);
        mb[0] = '0; mb[1] = '0; mdl_last = 1'b1;
        sb.delete();
        rif.rom_ok = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        push_tie(rif.addr0, rif.addr1);
        serve_next();
        serve_next();
        check("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
